// File: rtl/led_blink_pkg.sv
// Shared encodings and helpers for the led_blink_multi LED pattern engine.
package led_blink_pkg;

    localparam logic [1:0] MODE_OFF   = 2'b00;
    localparam logic [1:0] MODE_ON    = 2'b01;
    localparam logic [1:0] MODE_BLINK = 2'b10;
    localparam logic [1:0] MODE_BURST = 2'b11;

    localparam int BURST_W = 4;
    localparam int PULSE_W = BURST_W + 1;  // one extra bit so a count of 16 fits
    localparam int DUTY_W  = 4;

    typedef enum logic [2:0] {
        ST_OFF,
        ST_ON,
        ST_BLINK_LIT,
        ST_BLINK_DARK,
        ST_BURST_LIT,
        ST_BURST_DARK
    } ch_state_t;

    // A programmed burst count of zero stands for sixteen pulses.
    function automatic logic [PULSE_W-1:0] burst_count(input logic [BURST_W-1:0] b);
        return (b == '0) ? PULSE_W'(16) : {1'b0, b};
    endfunction

endpackage

// File: rtl/led_tick_gen.sv
// Shared prescaler: emits a single-cycle tick every g_CLK_HZ/g_TICK_HZ clocks.
module led_tick_gen #(
    parameter int g_CLK_HZ  = 25000000,
    parameter int g_TICK_HZ = 100
) (
    input  logic i_Clk,
    input  logic i_Rst_L,
    output logic o_Tick
);

    localparam int TICK_DIV = g_CLK_HZ / g_TICK_HZ;
    localparam int CNT_W    = (TICK_DIV > 1) ? $clog2(TICK_DIV) : 1;
    localparam logic [CNT_W-1:0] CNT_LAST = CNT_W'(TICK_DIV - 1);

    logic [CNT_W-1:0] cnt_reg;

    always_ff @(posedge i_Clk) begin
        if (!i_Rst_L) begin
            cnt_reg <= '0;
        end else if (cnt_reg == CNT_LAST) begin
            cnt_reg <= '0;
        end else begin
            cnt_reg <= cnt_reg + CNT_W'(1);
        end
    end

    assign o_Tick = (cnt_reg == CNT_LAST);

endmodule

// File: rtl/led_blink_multi.sv
// Multi-channel LED pattern engine (off / on / blink / counted burst).
// Define LED_BRIGHTNESS_EN to add per-channel 4-bit PWM duty gating.
module led_blink_multi
    import led_blink_pkg::*;
#(
    parameter int g_NUM_CH  = 4,
    parameter int g_CLK_HZ  = 25000000,
    parameter int g_TICK_HZ = 100,
    parameter int g_HALF_W  = 8
) (
    input  logic                i_Clk,
    input  logic                i_Rst_L,
    input  logic                i_Cfg_Valid,
    output logic                o_Cfg_Ready,
    input  logic [3:0]          i_Cfg_Ch,
    input  logic [1:0]          i_Cfg_Mode,
    input  logic [g_HALF_W-1:0] i_Cfg_Half,
    input  logic [3:0]          i_Cfg_Burst,
`ifdef LED_BRIGHTNESS_EN
    input  logic [DUTY_W-1:0]   i_Cfg_Duty,
`endif
    output logic [g_NUM_CH-1:0] o_LED,
    output logic [g_NUM_CH-1:0] o_Burst_Done
);

    logic ready_reg;
    logic accept;
    logic tick;

    always_ff @(posedge i_Clk) begin
        if (!i_Rst_L) begin
            ready_reg <= 1'b0;
        end else begin
            ready_reg <= 1'b1;
        end
    end

    assign o_Cfg_Ready = ready_reg;
    assign accept      = i_Cfg_Valid && ready_reg;

    led_tick_gen #(
        .g_CLK_HZ  (g_CLK_HZ),
        .g_TICK_HZ (g_TICK_HZ)
    ) u_tick (
        .i_Clk   (i_Clk),
        .i_Rst_L (i_Rst_L),
        .o_Tick  (tick)
    );

`ifdef LED_BRIGHTNESS_EN
    logic [DUTY_W-1:0] pwm_cnt_reg;

    always_ff @(posedge i_Clk) begin
        if (!i_Rst_L) begin
            pwm_cnt_reg <= '0;
        end else begin
            pwm_cnt_reg <= pwm_cnt_reg + DUTY_W'(1);
        end
    end
`endif

    for (genvar gi = 0; gi < g_NUM_CH; gi++) begin : g_ch
        ch_state_t            state_reg;
        logic                 led_reg;
        logic                 done_reg;
        logic [g_HALF_W-1:0]  half_reg;
        logic [g_HALF_W-1:0]  tick_cnt_reg;
        logic [PULSE_W-1:0]   burst_reg;
        logic [PULSE_W-1:0]   pulse_cnt_reg;
        logic                 wr;
        logic                 half_end;
        logic                 timed;

        assign wr       = accept && (i_Cfg_Ch == 4'(gi));
        assign half_end = (tick_cnt_reg == half_reg - g_HALF_W'(1));
        assign timed    = (state_reg == ST_BLINK_LIT) || (state_reg == ST_BLINK_DARK) ||
                          (state_reg == ST_BURST_LIT) || (state_reg == ST_BURST_DARK);

        // A config write takes priority over a coincident tick.
        always_ff @(posedge i_Clk) begin
            if (!i_Rst_L) begin
                state_reg     <= ST_OFF;
                led_reg       <= 1'b0;
                done_reg      <= 1'b0;
                half_reg      <= '0;
                tick_cnt_reg  <= '0;
                burst_reg     <= '0;
                pulse_cnt_reg <= '0;
            end else begin
                done_reg <= 1'b0;
                if (wr) begin
                    half_reg      <= (i_Cfg_Half == '0) ? g_HALF_W'(1) : i_Cfg_Half;
                    burst_reg     <= burst_count(i_Cfg_Burst);
                    tick_cnt_reg  <= '0;
                    pulse_cnt_reg <= '0;
                    led_reg       <= (i_Cfg_Mode != MODE_OFF);
                    case (i_Cfg_Mode)
                        MODE_OFF:   state_reg <= ST_OFF;
                        MODE_ON:    state_reg <= ST_ON;
                        MODE_BLINK: state_reg <= ST_BLINK_LIT;
                        default:    state_reg <= ST_BURST_LIT;
                    endcase
                end else if (tick && timed) begin
                    tick_cnt_reg <= half_end ? '0 : tick_cnt_reg + g_HALF_W'(1);
                    if (half_end) begin
                        case (state_reg)
                            ST_BLINK_LIT: begin
                                state_reg <= ST_BLINK_DARK;
                                led_reg   <= 1'b0;
                            end
                            ST_BLINK_DARK: begin
                                state_reg <= ST_BLINK_LIT;
                                led_reg   <= 1'b1;
                            end
                            ST_BURST_LIT: begin
                                state_reg <= ST_BURST_DARK;
                                led_reg   <= 1'b0;
                            end
                            default: begin
                                pulse_cnt_reg <= pulse_cnt_reg + PULSE_W'(1);
                                if (pulse_cnt_reg + PULSE_W'(1) == burst_reg) begin
                                    state_reg <= ST_OFF;
                                    done_reg  <= 1'b1;
                                end else begin
                                    state_reg <= ST_BURST_LIT;
                                    led_reg   <= 1'b1;
                                end
                            end
                        endcase
                    end
                end
            end
        end

`ifdef LED_BRIGHTNESS_EN
        logic [DUTY_W-1:0] duty_reg;

        always_ff @(posedge i_Clk) begin
            if (!i_Rst_L) begin
                duty_reg <= '0;
            end else if (wr) begin
                duty_reg <= i_Cfg_Duty;
            end
        end

        assign o_LED[gi] = led_reg && (pwm_cnt_reg < duty_reg);
`else
        assign o_LED[gi] = led_reg;
`endif
        assign o_Burst_Done[gi] = done_reg;
    end

endmodule

// File: tb/tb_led_blink_multi.sv
// Self-checking bench for led_blink_multi (TICK_DIV=10, 4 channels); covers the
// LED_BRIGHTNESS_EN build as well when that macro is defined.
module tb_led_blink_multi;

    localparam int NCH = 4;
    localparam int DIV = 10;

    logic       clk = 1'b0;
    logic       rst_l = 1'b0;
    logic       cfg_valid = 1'b0;
    logic       cfg_ready;
    logic [3:0] cfg_ch = '0;
    logic [1:0] cfg_mode = '0;
    logic [7:0] cfg_half = '0;
    logic [3:0] cfg_burst = '0;
    logic [3:0] cfg_duty = '0;
    logic [NCH-1:0] led;
    logic [NCH-1:0] done;

    led_blink_multi #(
        .g_NUM_CH  (NCH),
        .g_CLK_HZ  (100),
        .g_TICK_HZ (10),
        .g_HALF_W  (8)
    ) dut (
        .i_Clk        (clk),
        .i_Rst_L      (rst_l),
        .i_Cfg_Valid  (cfg_valid),
        .o_Cfg_Ready  (cfg_ready),
        .i_Cfg_Ch     (cfg_ch),
        .i_Cfg_Mode   (cfg_mode),
        .i_Cfg_Half   (cfg_half),
        .i_Cfg_Burst  (cfg_burst),
`ifdef LED_BRIGHTNESS_EN
        .i_Cfg_Duty   (cfg_duty),
`endif
        .o_LED        (led),
        .o_Burst_Done (done)
    );

    always #5 clk = ~clk;

    int errors = 0;
    int checks = 0;

    // Reference model: each channel remembers its programmed pattern and how many
    // ticks have elapsed since it was configured; the LED is derived arithmetically.
    int m_mode [NCH];
    int m_half [NCH];
    int m_burst[NCH];
    int m_duty [NCH];
    int m_t    [NCH];
    bit m_fin  [NCH];
    bit m_done [NCH];
    bit m_ready;
    int n_edges;

    typedef struct {
        logic [3:0] ch;
        logic [1:0] mode;
        logic [7:0] half;
        logic [3:0] burst;
        logic       exp_lit;
    } vec_t;

    vec_t tbl[6];

    task automatic chk(input string name, input logic [31:0] act, input logic [31:0] exp);
        checks++;
        if (act !== exp) begin
            errors++;
            if (errors <= 30)
                $display("FAIL %s: got %0h, expected %0h at t=%0t", name, act, exp, $time);
        end
    endtask

    function automatic bit gate(input int duty);
`ifdef LED_BRIGHTNESS_EN
        return (n_edges % 16) < duty;
`else
        return 1'b1;
`endif
    endfunction

    function automatic bit model_lit(input int ch);
        case (m_mode[ch])
            0:       return 1'b0;
            1:       return 1'b1;
            2:       return ((m_t[ch] / m_half[ch]) % 2) == 0;
            default: return !m_fin[ch] && (((m_t[ch] / m_half[ch]) % 2) == 0);
        endcase
    endfunction

    function automatic logic [NCH-1:0] exp_led();
        logic [NCH-1:0] e;
        for (int c = 0; c < NCH; c++) e[c] = model_lit(c) && gate(m_duty[c]);
        return e;
    endfunction

    function automatic logic [NCH-1:0] exp_done();
        logic [NCH-1:0] e;
        for (int c = 0; c < NCH; c++) e[c] = m_done[c];
        return e;
    endfunction

    task automatic model_edge();
        bit tick;
        bit acc;
        if (!rst_l) begin
            for (int c = 0; c < NCH; c++) begin
                m_mode[c] = 0; m_half[c] = 1; m_burst[c] = 16; m_duty[c] = 0;
                m_t[c] = 0; m_fin[c] = 0; m_done[c] = 0;
            end
            m_ready = 0;
            n_edges = 0;
        end else begin
            tick = (n_edges % DIV) == DIV - 1;
            acc  = cfg_valid && m_ready;
            for (int c = 0; c < NCH; c++) begin
                m_done[c] = 0;
                if (acc && int'(cfg_ch) == c) begin
                    m_mode[c]  = int'(cfg_mode);
                    m_half[c]  = (cfg_half == 0) ? 1 : int'(cfg_half);
                    m_burst[c] = (cfg_burst == 0) ? 16 : int'(cfg_burst);
                    m_duty[c]  = int'(cfg_duty);
                    m_t[c]     = 0;
                    m_fin[c]   = 0;
                end else if (tick && (m_mode[c] == 2 || (m_mode[c] == 3 && !m_fin[c]))) begin
                    m_t[c]++;
                    if (m_mode[c] == 3 && m_t[c] == 2 * m_burst[c] * m_half[c]) begin
                        m_fin[c]  = 1;
                        m_done[c] = 1;
                    end
                end
            end
            m_ready = 1;
            n_edges++;
        end
    endtask

    task automatic cycle();
        @(posedge clk);
        model_edge();
        #1;
        chk("led", led, exp_led());
        chk("burst_done", done, exp_done());
        chk("cfg_ready", cfg_ready, m_ready);
    endtask

    task automatic idle(input int n);
        cfg_valid = 1'b0;
        repeat (n) cycle();
    endtask

    task automatic write(input int ch, input int mode, input int half, input int burst, input int duty);
        cfg_valid = 1'b1;
        cfg_ch    = 4'(ch);
        cfg_mode  = 2'(mode);
        cfg_half  = 8'(half);
        cfg_burst = 4'(burst);
        cfg_duty  = 4'(duty);
        $display("cfg write ch=%0d mode=%0d half=%0d burst=%0d duty=%0d t=%0t", ch, mode, half, burst, duty, $time);
        cycle();
        cfg_valid = 1'b0;
    endtask

    // Idle until the next clock edge will sample a tick.
    task automatic align_tick();
        for (int k = 0; k < DIV && (n_edges % DIV) != DIV - 1; k++) idle(1);
    endtask

    task automatic do_reset(input int n);
        rst_l = 1'b0;
        idle(n);
        rst_l = 1'b1;
    endtask

    initial begin
        int cyc;
        int rises;
        int lit_cnt;
        int done_cnt;
        int hi_cnt;
        logic p;
        int tq[$];

        tbl[0] = '{ch: 4'd3, mode: 2'd1, half: 8'd1, burst: 4'd0, exp_lit: 1'b1};
        tbl[1] = '{ch: 4'd3, mode: 2'd0, half: 8'd4, burst: 4'd2, exp_lit: 1'b0};
        tbl[2] = '{ch: 4'd2, mode: 2'd2, half: 8'd3, burst: 4'd0, exp_lit: 1'b1};
        tbl[3] = '{ch: 4'd1, mode: 2'd3, half: 8'd2, burst: 4'd4, exp_lit: 1'b1};
        tbl[4] = '{ch: 4'd0, mode: 2'd0, half: 8'd0, burst: 4'd0, exp_lit: 1'b0};
        tbl[5] = '{ch: 4'd0, mode: 2'd1, half: 8'd7, burst: 4'd1, exp_lit: 1'b1};

        // Reset held for five cycles, ready on the first released edge.
        rst_l = 1'b0;
        for (int i = 0; i < 5; i++) begin
            cycle();
            chk("rst_ready", cfg_ready, 0);
            chk("rst_led", led, 0);
            chk("rst_done", done, 0);
        end
        rst_l = 1'b1;
        cycle();
        chk("ready_after_rst", cfg_ready, 1);

        for (int i = 0; i < 6; i++) begin
            write(tbl[i].ch, tbl[i].mode, tbl[i].half, tbl[i].burst, 15);
            chk("table_led", led[tbl[i].ch], tbl[i].exp_lit && gate(15));
            idle(3);
        end

        do_reset(2);
        idle(1);

`ifndef LED_BRIGHTNESS_EN
        // Blink ch0 half=2: steady 20-cycle toggles after the first, shortened half.
        write(0, 2, 2, 0, 15);
        p = led[0];
        cyc = 0;
        repeat (110) begin
            cycle();
            cyc++;
            if (led[0] !== p) begin
                tq.push_back(cyc);
                p = led[0];
            end
        end
        chk("blink_toggle_count", tq.size() >= 4, 1);
        for (int k = 1; k < tq.size(); k++) chk("blink_period", tq[k] - tq[k-1], 20);

        // Tick-aligned burst of three on ch1, half=1.
        align_tick();
        p = 1'b0;
        rises = 0; lit_cnt = 0; done_cnt = 0;
        write(1, 3, 1, 3, 15);
        for (int i = 0; i < 80; i++) begin
            if (i > 0) cycle();
            if (led[1] && !p) rises++;
            if (led[1]) lit_cnt++;
            if (done[1]) done_cnt++;
            p = led[1];
        end
        chk("burst_rises", rises, 3);
        chk("burst_lit_cycles", lit_cnt, 30);
        chk("burst_done_pulses", done_cnt, 1);
`endif

        // ch2 half=0 behaves as half=1; out-of-range channel write is swallowed.
        write(2, 2, 0, 0, 15);
        write(7, 1, 3, 0, 15);
        chk("ch7_ready", cfg_ready, 1);
        idle(40);

        // Rewrite ch1 to on during a burst, on a tick edge.
        write(1, 3, 2, 5, 15);
        idle(25);
        align_tick();
        write(1, 1, 1, 0, 15);
        chk("rewrite_on_led", led[1], gate(15));
        done_cnt = 0;
        for (int i = 0; i < 30; i++) begin
            cycle();
            if (done[1]) done_cnt++;
        end
        chk("rewrite_no_done", done_cnt, 0);

        // Write landing on the very edge a burst would complete.
        write(1, 3, 1, 1, 15);
        for (int k = 0; k < 60 && !((n_edges % DIV) == DIV - 1 && m_t[1] == 1); k++) idle(1);
        chk("burst_end_align", ((n_edges % DIV) == DIV - 1) && (m_t[1] == 1), 1);
        write(1, 2, 3, 0, 15);
        chk("end_write_no_done", done[1], 0);
        chk("end_write_led", led[1], gate(15));
        idle(5);

        // Reset mid-blink.
        write(0, 2, 1, 0, 15);
        idle(7);
        rst_l = 1'b0;
        cycle();
        chk("midrst_led", led, 0);
        chk("midrst_done", done, 0);
        chk("midrst_ready", cfg_ready, 0);
        rst_l = 1'b1;
        idle(2);

`ifdef LED_BRIGHTNESS_EN
        write(3, 1, 1, 0, 4);
        hi_cnt = 0;
        repeat (32) begin
            cycle();
            if (led[3]) hi_cnt++;
        end
        chk("duty4_high_cycles", hi_cnt, 8);
`endif

        // Randomized traffic against the model.
        for (int i = 0; i < 1500; i++) begin
            if ($urandom_range(0, 299) == 0) begin
                rst_l = 1'b0;
                idle(1);
                rst_l = 1'b1;
            end
            if ($urandom_range(0, 7) == 0) begin
                write($urandom_range(0, 7), $urandom_range(0, 3), $urandom_range(0, 3),
                      $urandom_range(0, 3), $urandom_range(0, 15));
            end else begin
                cfg_valid = 1'b0;
                cfg_ch    = 4'($urandom_range(0, 15));
                cfg_mode  = 2'($urandom_range(0, 3));
                cycle();
            end
        end

        $display("Result: errors=%0d of %0d checks", errors, checks);
        $finish;
    end

endmodule
